nco_out_serializer: RTL and testbench

- Core-side stage directly upstream of the chip output terminal.
- Accepts one 12-bit X/Y sample pair plus an invert-sign flag from the NCO datapath over a valid/ready handshake.
- Transmits each sample as a framed burst: a one-cycle Rdy strobe, then six 2-bit chunks per axis, LSB chunk first.
- A one-entry shadow buffer lets the next sample be accepted while the current frame is shifting.

---
 rtl/nco_io_pkg.sv | 34 +++
 rtl/nco_skid1.sv | 47 ++++
 rtl/nco_out_serializer.sv | 131 +++++++++++++
 tb/tb_nco_out_serializer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_io_pkg.sv
// Shared definitions for the NCO output serializer.
// Holds the sample/chunk geometry, the frame FSM state encoding, the
// sample record carried through the shadow and active registers, and a
// helper that selects one chunk of a sample.
package nco_io_pkg;

  localparam int DATA_W    = 12;
  localparam int CHUNK_W   = 2;
  localparam int NCHUNK    = DATA_W / CHUNK_W;
  localparam int CNT_W     = $clog2(NCHUNK);
  // START + NCHUNK shift cycles + TAIL
  localparam int FRAME_LEN = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    TAIL,
    GAPW
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic              inv;
  } sample_t;

  // Chunk k of a sample, LSB chunk is k = 0.
  function automatic logic [CHUNK_W-1:0] chunk_of(input logic [DATA_W-1:0] d,
                                                  input logic [CNT_W-1:0]  k);
    return d[k*CHUNK_W +: CHUNK_W];
  endfunction

endpackage

// File: rtl/nco_skid1.sv
// One-entry shadow buffer in front of the serializer's active register.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_valid/o_ready upstream handshake; o_ready is high when empty or when
//                   the entry is being popped on this edge
//   i_data          sample offered upstream
//   i_pop           consumer moves the entry out on this edge (only when full)
//   o_full/o_data   entry occupancy and contents
module nco_skid1
  import nco_io_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_valid,
  output logic    o_ready,
  input  sample_t i_data,
  input  logic    i_pop,
  output logic    o_full,
  output sample_t o_data
);

  logic    r_full;
  sample_t r_data;
  logic    w_push;

  // Pop and push on the same edge is allowed: the slot is refilled as it drains.
  assign o_ready = !r_full || i_pop;
  assign w_push  = i_valid && o_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      // NOTE: the data word is reset as well; it is small, and a defined value
      // keeps a stale sample from ever reaching the outputs after reset.
      r_data <= '0;
    end else begin
      if (w_push) r_data <= i_data;
      r_full <= w_push || (r_full && !i_pop);
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/nco_out_serializer.sv
// NCO output serializer: takes one X/Y sample pair plus invert-sign flag per
// handshake and sends it as a frame: one Rdy strobe cycle, NCHUNK cycles of
// CHUNK_W-bit X/Y chunks (LSB chunk first), one TAIL cycle, then GAP idle cycles.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     sample handshake (in_ready is combinational)
//   in_x, in_y, in_inv    sample pair and invert-sign request
//   Rdy                   one-cycle frame-start strobe
//   Xout, Yout            current X/Y chunk, zero outside SHIFT
//   ISout                 invert-sign flag of the current frame
//   busy                  a frame is in progress
// All outputs except in_ready are flops loaded from next-state values.
module nco_out_serializer
  import nco_io_pkg::*;
#(
  parameter int GAP = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_x,
  input  logic [DATA_W-1:0]  in_y,
  input  logic               in_inv,
  output logic               Rdy,
  output logic [CHUNK_W-1:0] Xout,
  output logic [CHUNK_W-1:0] Yout,
  output logic               ISout,
  output logic               busy
);

  localparam int                GW        = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0]     GAP_LAST  = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NCHUNK - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [GW-1:0]    r_gap, w_gap_nxt;
  sample_t          r_act;
  sample_t          w_in_data, w_shadow;
  logic             w_shadow_full, w_launch;

  assign w_in_data = '{x: in_x, y: in_y, inv: in_inv};

  nco_skid1 u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in_data),
    .i_pop   (w_launch),
    .o_full  (w_shadow_full),
    .o_data  (w_shadow)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_launch    = 1'b0;

    case (r_state)
      IDLE:  w_launch = w_shadow_full;
      START: w_state_nxt = SHIFT;
      SHIFT: begin
        if (r_cnt == CNT_LAST) w_state_nxt = TAIL;
        else                   w_cnt_nxt   = r_cnt + 1'b1;
      end
      TAIL: begin
        if (GAP == 0) begin
          w_state_nxt = IDLE;
          w_launch    = w_shadow_full;
        end else begin
          w_state_nxt = GAPW;
          w_gap_nxt   = '0;
        end
      end
      GAPW: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = IDLE;
          w_launch    = w_shadow_full;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Launch overrides the fall-back to IDLE and restarts the chunk counter.
    if (w_launch) begin
      w_state_nxt = START;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_act   <= '0;
      Rdy     <= 1'b0;
      Xout    <= '0;
      Yout    <= '0;
      ISout   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      if (w_launch) begin
        r_act <= w_shadow;
        ISout <= w_shadow.inv;
      end
      Rdy  <= (w_state_nxt == START);
      busy <= (w_state_nxt != IDLE);
      // The active register is stable during SHIFT, so the chunk for the next
      // cycle can be selected with the next counter value.
      if (w_state_nxt == SHIFT) begin
        Xout <= chunk_of(r_act.x, w_cnt_nxt);
        Yout <= chunk_of(r_act.y, w_cnt_nxt);
      end else begin
        Xout <= '0;
        Yout <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nco_out_serializer.sv
// Scoreboard bench for nco_out_serializer: one instance with GAP = 0 and one
// with GAP = 3. Accepted samples push hand-computed chunk lists into a queue;
// a monitor per instance pops at each Rdy and follows the frame cycle by cycle.
module tb_nco_out_serializer;
  import nco_io_pkg::*;

  typedef struct packed {
    logic            inv;
    logic [5:0][1:0] xc;
    logic [5:0][1:0] yc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid [2];
  logic        in_ready [2];
  logic [11:0] in_x     [2];
  logic [11:0] in_y     [2];
  logic        in_inv   [2];
  logic        rdy      [2];
  logic [1:0]  xout     [2];
  logic [1:0]  yout     [2];
  logic        isout    [2];
  logic        busy     [2];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   acc_cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   rdy_t0[$];
  int   rdy_t1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nco_out_serializer #(.GAP(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_x(in_x[0]), .in_y(in_y[0]), .in_inv(in_inv[0]),
    .Rdy(rdy[0]), .Xout(xout[0]), .Yout(yout[0]), .ISout(isout[0]), .busy(busy[0])
  );

  nco_out_serializer #(.GAP(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_x(in_x[1]), .in_y(in_y[1]), .in_inv(in_inv[1]),
    .Rdy(rdy[1]), .Xout(xout[1]), .Yout(yout[1]), .ISout(isout[1]), .busy(busy[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  function automatic int qsize(input int idx);
    return (idx == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int last_rdy(input int idx);
    if (idx == 0) return (rdy_t0.size() > 0) ? rdy_t0[rdy_t0.size()-1] : -1;
    return (rdy_t1.size() > 0) ? rdy_t1[rdy_t1.size()-1] : -1;
  endfunction

  // Follows one frame per Rdy: START, NCHUNK chunk cycles, TAIL.
  task automatic mon_run(input int idx, input int gap);
    int   phase;
    int   last;
    int   k;
    exp_t cur;
    phase = 0;
    last  = -1000;
    cur   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
        last  = -1000;
      end else if (phase == 0) begin
        if (rdy[idx]) begin
          if (qsize(idx) == 0) begin
            check("rdy_without_sample", rdy[idx], 1'b0);
          end else begin
            if (idx == 0) cur = q0.pop_front();
            else          cur = q1.pop_front();
            check("start_isout", isout[idx], cur.inv);
            check("start_x", xout[idx], 2'd0);
            check("start_y", yout[idx], 2'd0);
            check("start_busy", busy[idx], 1'b1);
            check("rdy_spacing", (cyc - last) >= (FRAME_LEN + gap), 1'b1);
            last = cyc;
            if (idx == 0) rdy_t0.push_back(cyc);
            else          rdy_t1.push_back(cyc);
            phase = 1;
          end
        end else begin
          check("idle_x", xout[idx], 2'd0);
          check("idle_y", yout[idx], 2'd0);
        end
      end else if (phase <= NCHUNK) begin
        k = phase - 1;
        check("shift_rdy", rdy[idx], 1'b0);
        check("chunk_x", xout[idx], cur.xc[k]);
        check("chunk_y", yout[idx], cur.yc[k]);
        check("shift_isout", isout[idx], cur.inv);
        phase++;
      end else begin
        check("tail_rdy", rdy[idx], 1'b0);
        check("tail_x", xout[idx], 2'd0);
        check("tail_y", yout[idx], 2'd0);
        check("tail_isout", isout[idx], cur.inv);
        check("tail_busy", busy[idx], 1'b1);
        phase = 0;
      end
    end
  endtask

  initial mon_run(0, 0);
  initial mon_run(1, 3);

  // Called at posedge+1; holds the sample until accepted, returns cycles waited.
  task automatic send(input int idx, input logic [11:0] x, input logic [11:0] y,
                      input logic inv, input logic [11:0] xc, input logic [11:0] yc,
                      output int waited);
    exp_t e;
    bit   acc;
    e.inv = inv;
    e.xc  = xc;
    e.yc  = yc;
    in_valid[idx] = 1'b1;
    in_x[idx]     = x;
    in_y[idx]     = y;
    in_inv[idx]   = inv;
    waited = 0;
    acc    = 1'b0;
    while (!acc && waited < 40) begin
      #7;
      if (in_ready[idx]) begin
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
        acc_cyc = cyc;
        acc     = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", in_ready[idx], 1'b1);
    in_valid[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx);
    int n;
    n = 0;
    while ((qsize(idx) != 0 || busy[idx]) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      check("drain_busy", busy[idx], 1'b0);
      check("drain_pending", qsize(idx), 0);
    end
  endtask

  task automatic goto_cycle(input int c);
    int n;
    n = 0;
    while (cyc < c && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, a, b, c, t, r0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      in_x[i]     = '0;
      in_y[i]     = '0;
      in_inv[i]   = 1'b0;
    end
    #2;
    for (int i = 0; i < 2; i++) begin
      check("reset_rdy", rdy[i], 1'b0);
      check("reset_x", xout[i], 2'd0);
      check("reset_y", yout[i], 2'd0);
      check("reset_isout", isout[i], 1'b0);
      check("reset_busy", busy[i], 1'b0);
      check("reset_in_ready", in_ready[i], 1'b1);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single sample X=0xA5C Y=0x3F1: X chunks 0,3,1,1,2,2  Y chunks 1,0,3,3,3,0
    send(0, 12'hA5C, 12'h3F1, 1'b0,
         {2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0}, {2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1}, w);
    check("single_wait", w, 0);
    t = acc_cyc + 2;
    goto_cycle(t + 7);
    check("single_busy_tail", busy[0], 1'b1);
    goto_cycle(t + 8);
    check("single_busy_after", busy[0], 1'b0);
    check("single_rdy_cycle", last_rdy(0), t);

    // Back-to-back A, B, then C waits for the same-edge drain/refill at A's TAIL.
    r0 = rdy_t0.size();
    send(0, 12'h123, 12'h456, 1'b0,
         {2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3}, {2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2}, w);
    a = acc_cyc;
    send(0, 12'hFFF, 12'h000, 1'b1,
         {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0}, w);
    b = acc_cyc;
    check("b2b_b_wait", w, 0);
    check("b2b_b_accept", b, a + 1);
    send(0, 12'h5A5, 12'h0C3, 1'b0,
         {2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1}, {2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3}, w);
    c = acc_cyc;
    check("full_backpressure_cycles", w, 7);
    check("refill_accept_cycle", c, a + 9);
    wait_done(0);
    check("b2b_frames", rdy_t0.size(), r0 + 3);
    if (rdy_t0.size() == r0 + 3) begin
      check("b2b_first_rdy", rdy_t0[r0], a + 2);
      check("b2b_period_ab", rdy_t0[r0+1] - rdy_t0[r0], 8);
      check("b2b_period_bc", rdy_t0[r0+2] - rdy_t0[r0+1], 8);
    end

    // Invert flag: X=0x001 -> 1,0,0,0,0,0  Y=0xFFF -> all 3
    send(0, 12'h001, 12'hFFF, 1'b1,
         {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1}, {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, w);
    wait_done(0);
    check("inv_held_after_frame", isout[0], 1'b1);

    // GAP = 3 instance: two queued samples, Rdy at t and t+11.
    r0 = rdy_t1.size();
    send(1, 12'hA5C, 12'h3F1, 1'b0,
         {2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0}, {2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1}, w);
    t = acc_cyc + 2;
    send(1, 12'h001, 12'hFFF, 1'b1,
         {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1}, {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, w);
    goto_cycle(t + 9);
    check("gap_busy", busy[1], 1'b1);
    check("gap_rdy_low", rdy[1], 1'b0);
    check("gap_in_ready_full", in_ready[1], 1'b0);
    wait_done(1);
    check("gap_frames", rdy_t1.size(), r0 + 2);
    if (rdy_t1.size() == r0 + 2) begin
      check("gap_first_rdy", rdy_t1[r0], t);
      check("gap_period", rdy_t1[r0+1] - rdy_t1[r0], 11);
    end

    // Reset in the middle of a frame with a second sample waiting in the shadow.
    send(0, 12'hA5C, 12'h3F1, 1'b1,
         {2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd0}, {2'd0, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1}, w);
    t = acc_cyc + 2;
    send(0, 12'h123, 12'h456, 1'b0,
         {2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3}, {2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2}, w);
    goto_cycle(t + 3);
    check("pre_reset_x", xout[0], 2'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_rdy", rdy[0], 1'b0);
    check("async_reset_x", xout[0], 2'd0);
    check("async_reset_y", yout[0], 2'd0);
    check("async_reset_isout", isout[0], 1'b0);
    check("async_reset_busy", busy[0], 1'b0);
    check("async_reset_in_ready", in_ready[0], 1'b1);
    q0.delete();
    q1.delete();
    #3 rst = 1'b0;
    r0 = rdy_t0.size();
    repeat (15) @(posedge clk);
    #1;
    check("no_rdy_after_reset", rdy_t0.size(), r0);
    check("idle_after_reset_busy", busy[0], 1'b0);
    send(0, 12'h5A5, 12'h0C3, 1'b0,
         {2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1}, {2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3}, w);
    a = acc_cyc;
    wait_done(0);
    check("post_reset_frames", rdy_t0.size(), r0 + 1);
    check("post_reset_rdy_cycle", last_rdy(0), a + 2);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
